// File: rtl/key_event_conditioner.sv
// Multi-channel push-button front end: synchronises, debounces and classifies key
// presses into short/long events with auto-repeat while a key is held.
module key_event_conditioner #(
  parameter int NUM_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES   = 2000000,
  parameter int LONG_PRESS_CYCLES = 200000000,
  parameter int REPEAT_CYCLES     = 25000000,
  parameter int CNT_W             = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] short_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse,
  output logic [NUM_KEYS-1:0] long_held
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_LONG
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;

  // Synchronisers ignore enable so a key held across a disable is seen at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    state_e           state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;
    logic             held_q, held_d;
    logic             flip;

    always_comb begin
      state_d    = state_q;
      deb_cnt_d  = deb_cnt_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      level_d    = level_q;
      held_d     = held_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      short_d    = 1'b0;
      long_d     = 1'b0;
      rep_d      = 1'b0;
      flip       = 1'b0;

      if (!enable) begin
        state_d    = S_IDLE;
        deb_cnt_d  = '0;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
        level_d    = 1'b0;
        held_d     = 1'b0;
      end else begin
        if (sync2_q[g] != level_q) begin
          if (deb_cnt_q == DEB_LAST) begin
            flip      = 1'b1;
            level_d   = sync2_q[g];
            deb_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end else begin
          deb_cnt_d = '0;
        end

        press_d   = flip & sync2_q[g];
        release_d = flip & ~sync2_q[g];

        // A release always wins over a long or repeat threshold on the same edge.
        case (state_q)
          S_IDLE: begin
            if (press_d) begin
              state_d    = S_PRESSED;
              hold_cnt_d = '0;
            end
          end
          S_PRESSED: begin
            if (release_d) begin
              state_d    = S_IDLE;
              short_d    = 1'b1;
              hold_cnt_d = '0;
            end else if (hold_cnt_q == LONG_LAST) begin
              state_d    = S_LONG;
              long_d     = 1'b1;
              held_d     = 1'b1;
              hold_cnt_d = '0;
              rep_cnt_d  = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
          S_LONG: begin
            if (release_d) begin
              state_d   = S_IDLE;
              held_d    = 1'b0;
              rep_cnt_d = '0;
            end else if (rep_cnt_q == REP_LAST) begin
              rep_d     = 1'b1;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q    <= S_IDLE;
        deb_cnt_q  <= '0;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        short_q    <= 1'b0;
        long_q     <= 1'b0;
        rep_q      <= 1'b0;
        held_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        deb_cnt_q  <= deb_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        rep_cnt_q  <= rep_cnt_d;
        level_q    <= level_d;
        press_q    <= press_d;
        release_q  <= release_d;
        short_q    <= short_d;
        long_q     <= long_d;
        rep_q      <= rep_d;
        held_q     <= held_d;
      end
    end

    assign key_level[g]     = level_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = release_q;
    assign short_pulse[g]   = short_q;
    assign long_pulse[g]    = long_q;
    assign repeat_pulse[g]  = rep_q;
    assign long_held[g]     = held_q;
  end

endmodule

// File: doc/key_event_conditioner.md
Name: key_event_conditioner

Overview:
- Multi-channel push-button front end for the clock/timer mode blocks: synchronises raw keys, debounces them, classifies each press as short or long, and generates auto-repeat ticks while a key is held.
- Sits directly upstream of the timer/set-mode logic, which consumes only clean single-cycle event pulses and never sees raw buttons.
- One independent channel per key; all channels share the timing parameters.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 2000000, consecutive cycles of a new synchronised level required to accept it (20 ms at 100 MHz); must be >= 1.
- LONG_PRESS_CYCLES, 200000000, cycles after press_pulse at which a held key becomes a long press (2 s); must be >= 1.
- REPEAT_CYCLES, 25000000, auto-repeat period while in long press (250 ms); must be >= 1.
- CNT_W, 32, width of every internal counter; must hold the largest cycle parameter.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- enable, input, 1, channel enable (driven by power state); low = synchronous clear of all channels.
- key_raw, input, NUM_KEYS, raw asynchronous buttons, active high.
- key_level, output, NUM_KEYS, debounced key level.
- press_pulse, output, NUM_KEYS, 1-cycle pulse on debounced 0->1.
- release_pulse, output, NUM_KEYS, 1-cycle pulse on debounced 1->0.
- short_pulse, output, NUM_KEYS, 1-cycle pulse on release of a press that never reached long.
- long_pulse, output, NUM_KEYS, 1-cycle pulse when a hold reaches LONG_PRESS_CYCLES.
- repeat_pulse, output, NUM_KEYS, 1-cycle pulse every REPEAT_CYCLES while long-held.
- long_held, output, NUM_KEYS, level, high from the long_pulse cycle until release.

Behaviour:
- Clock clk; reset is asynchronous, active-low. During reset, all outputs are 0, all counters are 0, synchronisers are 0, and every FSM is IDLE.
- All outputs are registered. Bit i of every output belongs to channel i only, and channels never interact.
- Synchroniser: 2-flop chain per key; s_i is the second flop.
- Debounce: the counter increments each cycle while s_i != key_level[i] and clears to 0 when they are equal.
  - When the counter is at DEBOUNCE_CYCLES-1 and s_i != key_level[i], the next edge updates key_level[i] and clears the counter.
  - Latency from the first clk edge sampling raw high to key_level rising is 2+DEBOUNCE_CYCLES cycles. Release is symmetric.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no event.
- press_pulse and release_pulse are asserted in the same cycle key_level changes.
- Per-channel FSM:
  - IDLE: on debounced rise, go to PRESSED, hold_cnt=0.
  - PRESSED: hold_cnt increments each cycle.
    - At hold_cnt==LONG_PRESS_CYCLES-1, go to LONG, fire long_pulse, set long_held, rep_cnt=0. long_pulse therefore appears exactly LONG_PRESS_CYCLES cycles after press_pulse.
    - On debounced fall, go to IDLE and fire release_pulse and short_pulse together.
  - LONG: rep_cnt increments each cycle. At rep_cnt==REPEAT_CYCLES-1, fire repeat_pulse and clear rep_cnt. The first repeat comes REPEAT_CYCLES after long_pulse.
    - On debounced fall, go to IDLE, fire release_pulse, clear long_held. No short_pulse.
- Simultaneous events:
  - A debounced fall on the same cycle as the long threshold is a release: short_pulse fires, no long_pulse.
  - A fall on the same cycle as the repeat threshold: release only, no repeat_pulse.
- Counters saturate by construction: they stop at their thresholds and never wrap.
- enable low: next edge forces key_level, all pulses, long_held, and counters to 0 and FSMs to IDLE. No release or short pulse is emitted. Synchronisers keep sampling.
- Re-enable with a key already held: the key must re-qualify via the full debounce from key_level=0, then a fresh press_pulse fires.
- Reset asserted mid-press: immediate clear. After deassertion, behaves as the re-enable case.

Test Plan (NUM_KEYS=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=5, enable=1):
- Glitch: key_raw[0] high for 3 cycles, then low -> key_level and all pulses stay 0 throughout.
- Short press: key_raw[0] high 12 cycles -> key_level[0] rises 6 cycles after first high sample, with press_pulse[0] for 1 cycle; falls 12 cycles later with release_pulse[0] and short_pulse[0] in the same cycle; long_pulse never fires.
- Long press: key_raw[0] high 40 cycles -> long_pulse at press+20; repeat_pulse at press+25, +30, +35; release at press+40 with release_pulse, long_held cleared, no short_pulse, no repeat on the release cycle.
- Independence: key 0 short press overlapping key 1 long press, with staggered edges -> each channel's pulses exactly match its single-key timing; no cross-talk.
- Disable mid-long: enable low at press+25 -> the next cycle all outputs are 0 with no release_pulse. Re-enable with the key still held -> press_pulse 4 cycles later, and long_pulse 20 cycles after that.
- Async reset mid-repeat: reset low between edges -> outputs 0 immediately. After release of reset with the key held -> press_pulse after 2+4 cycles.
